instruction_decode: RTL
=======================

// Module: instruction_decode
// PURPOSE
//  - Decode stage directly downstream of the instruction fetch stage in the custom 4-stage 8-bit pipeline.
//  - Registers the fetched Instruction_Code into an IF/ID register, decodes it and reads the 8x8 register file.
//  - Presents operands to execute through an ID/EX register.
//  - Resolves JMP in decode: drives adr_sel/jmp_addr back to fetch and squashes the one shadow instruction.
// PARAMETERS
//  DATA_W     8  register/operand width (encoding fixes the register address at 3 bits)
//  RF_RST_VAL 0  value loaded into every register-file entry on reset
// PORTS
//  clk               in   1       rising-edge clock, single domain
//  reset             in   1       synchronous, active-high; clears all state
//  Instruction_Code  in   8       combinational instruction from fetch for the current PC
//  wb_en             in   1       writeback enable from the last stage
//  wb_addr           in   3       writeback destination register
//  wb_data           in   DATA_W  writeback data
//  adr_sel           out  1       1 = fetch takes PC <= PC + jmp_addr at the next edge
//  jmp_addr          out  8       sign-extended jump offset, relative to jmp_pc+1
//  ex_valid          out  1       ID/EX holds a real ALU/LDI op
//  ex_op             out  2       00 ADD, 01 SUB, 10 LDI
//  ex_rd             out  3       destination register
//  ex_a              out  DATA_W  R[rd] for ADD/SUB; 0 for LDI
//  ex_b              out  DATA_W  R[rs] for ADD/SUB; zero-extended imm3 for LDI
// BEHAVIOUR
//  - Instruction encoding, instr[7:6] = opcode:
//      00 ADD rd,rs: rd=[5:3], rs=[2:0], R[rd] <= R[rd] + R[rs]
//      01 SUB rd,rs: same fields, R[rd] <= R[rd] - R[rs]
//      10 LDI rd,imm: rd=[5:3], imm=[2:0]
//      11 JMP off: off=[5:0], two's complement
//  - Reset (sampled at posedge):
//      if_id_valid=0, if_id_instr=0, all ID/EX fields=0, all RF entries=RF_RST_VAL.
//      Outputs read adr_sel=0, jmp_addr=0, ex_valid=0, ex_op=0, ex_rd=0, ex_a=0, ex_b=0.
//  - IF/ID register: each non-reset edge captures Instruction_Code.
//      if_id_valid <= ~jump_taken, so the shadow instruction is squashed.
//      The first cycle after reset release has if_id_valid=0.
//  - jump_taken = if_id_valid & (opcode==11). Combinational from IF/ID only; no input-to-output path.
//  - adr_sel = jump_taken.
//      jmp_addr = {{2{off[5]}},off} when jump_taken, else 8'h00.
//      Net target = jmp_pc + 1 + sext(off).
//  - Penalty and bursts:
//      JMP costs exactly one bubble.
//      Back-to-back JMPs: the second is in the shadow, squashed, and does not jump.
//  - ID/EX register:
//      ex_valid <= if_id_valid & (opcode != 11); a JMP never reaches execute.
//      When invalid, the operand fields still load but are don't-care.
//      Latency is 1 cycle from IF/ID to ID/EX, i.e. 2 edges from fetch.
//  - Register file:
//      8 x DATA_W, 2 combinational reads (rd, rs), 1 synchronous write on wb_en.
//      Write-first bypass: if wb_en & wb_addr==read address in the same cycle, the read returns wb_data.
//      Writes to any of r0..r7 are legal; r0 is not hardwired.
//  - Width: no arithmetic here. imm3 is zero-extended; off6 is sign-extended to 8 bits.
//  - Reset mid-operation dominates everything: pending jump, write and squash are all dropped.
//      adr_sel reads 0 while reset is asserted.
// STRUCTURE
//  - Shared package (pipe_pkg):
//      opcode localparams OP_ADD/OP_SUB/OP_LDI/OP_JMP
//      field bit positions
//      DATA_W default
//  - Sub-module regfile_8x (2R1W with write-first bypass and sync reset).
//  - Remainder: IF/ID register, decode logic, ID/EX register.
// TESTING
//  1. Reset held 2 cycles, then released.
//       -> all outputs 0; ex_valid stays 0 for 2 edges after release.
//  2. wb r1=0x10 and r2=0x03, then Instruction_Code=0x0A (ADD r1,r2).
//       -> two edges later: ex_valid=1, ex_op=00, ex_rd=1, ex_a=0x10, ex_b=0x03.
//  3. Instruction_Code=0x9D (LDI r3,5).
//       -> ex_op=10, ex_rd=3, ex_a=0x00, ex_b=0x05.
//  4. 0xC3 (JMP +3) then 0x0A in the shadow.
//       -> adr_sel=1, jmp_addr=0x03 for one cycle; the following ex_valid=0 (one bubble); shadow ADD never issues.
//  5. 0xFE (JMP -2) followed by 0xC1 in the shadow.
//       -> jmp_addr=0xFE for one cycle; second JMP squashed, adr_sel low the next cycle.
//  6. wb_en=1, wb_addr=2, wb_data=0x55 in the same cycle ADD r1,r2 is decoded.
//       -> ex_b=0x55 (bypass).
//     Separately, assert reset while a JMP sits in IF/ID.
//       -> adr_sel=0 at that cycle and all outputs 0 at the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline: opcodes, field positions
// and the default datapath width.
package pipe_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int RS_HI  = 2;
    localparam int RS_LO  = 0;
    localparam int OFF_HI = 5;

endpackage

// File: rtl/regfile_8x.sv
// 8-entry register file, two combinational reads, one synchronous write.
// A read of the address being written this cycle returns the new data.
module regfile_8x #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] mem [8];

    // Write port; reset loads every entry with the reset value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports with write-first bypass
    always_comb begin
        ra_data = mem[ra_addr];
        rb_data = mem[rb_addr];
        if (wr_en && wr_addr == ra_addr) ra_data = wr_data;
        if (wr_en && wr_addr == rb_addr) rb_data = wr_data;
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, decode, register-file read, ID/EX register.
// JMP resolves here and squashes the single shadow instruction.
module instruction_decode
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = pipe_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        Instruction_Code,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              adr_sel,
    output logic [7:0]        jmp_addr,
    output logic              ex_valid,
    output logic [1:0]        ex_op,
    output logic [2:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b
);

    logic              if_id_valid;
    logic [7:0]        if_id_instr;
    logic [1:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [5:0]        off;
    logic              jump_taken;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;

    assign opcode     = if_id_instr[OPC_HI:OPC_LO];
    assign rd         = if_id_instr[RD_HI:RD_LO];
    assign rs         = if_id_instr[RS_HI:RS_LO];
    assign off        = if_id_instr[OFF_HI:0];
    assign jump_taken = if_id_valid && (opcode == OP_JMP);

    // Reset wins over a pending jump so fetch never redirects during reset
    always_comb begin
        adr_sel  = 1'b0;
        jmp_addr = 8'h00;
        if (jump_taken && !reset) begin
            adr_sel  = 1'b1;
            jmp_addr = {{2{off[5]}}, off};
        end
    end

    regfile_8x #(
        .DATA_W  (DATA_W),
        .RST_VAL (RF_RST_VAL)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data),
        .ra_addr (rd),
        .ra_data (rd_data),
        .rb_addr (rs),
        .rb_data (rs_data)
    );

    // IF/ID register; the instruction behind a taken jump is marked invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_instr <= 8'h00;
        end else begin
            if_id_valid <= ~jump_taken;
            if_id_instr <= Instruction_Code;
        end
    end

    // ID/EX register; LDI carries 0 and the zero-extended immediate
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_op    <= 2'b00;
            ex_rd    <= 3'd0;
            ex_a     <= '0;
            ex_b     <= '0;
        end else begin
            ex_valid <= if_id_valid && (opcode != OP_JMP);
            ex_op    <= opcode;
            ex_rd    <= rd;
            if (opcode == OP_LDI) begin
                ex_a <= '0;
                ex_b <= {{(DATA_W-3){1'b0}}, rs};
            end else begin
                ex_a <= rd_data;
                ex_b <= rs_data;
            end
        end
    end

endmodule
